pipe_reg_hs: RTL and testbench

Parametrised pipeline register with a valid/ready handshake and a two-entry skid buffer. It is the successor of the plain enabled register used between datapath stages. It replaces the single `enable` control with back-pressure (`out_ready`), a synchronous `flush`, and full throughput with no combinational path from `out_ready` to `in_ready`. It sits between pipeline stages of the processor datapath, for example IF/ID, ID/EX, EX/MEM and MEM/WB, where stalls and squashes must not drop or duplicate data.

---
 rtl/pipe_reg_hs.sv | 118 +++++++++++
 tb/tb_pipe_reg_hs.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_hs.sv
// Pipeline register with valid/ready handshake and a two-entry skid buffer.
// Ready and valid are decoded from state only, so nothing ripples from downstream to upstream.
module pipe_reg_hs #(
  parameter int          N         = 64,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  input  logic         flush,
  output logic [1:0]   count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] main_q;
  logic [N-1:0] main_nx;
  logic [N-1:0] skid_q;
  logic [N-1:0] skid_nx;
  logic         accept;
  logic         pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign out_data = main_q;

  // Handshake outputs depend on the state register alone.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    count     = 2'd0;
    unique case (state)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
      end
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        count     = 2'd1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        count     = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
      end
    endcase
  end

  // Next state and data loads; flush squashes occupancy but keeps data.
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx = ONE;
            main_nx  = in_data;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_nx = in_data;
          end else if (accept) begin
            state_nx = FULL;
            skid_nx  = in_data;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nx = ONE;
            main_nx  = skid_q;
          end
        end
        default: begin
          state_nx = EMPTY;
        end
      endcase
    end
  end

  // State and storage registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      main_q <= RESET_VAL;
      skid_q <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Bench for pipe_reg_hs: directed table, reset corner case,
// then random traffic against a two-deep queue model.
module tb_pipe_reg_hs;

  localparam int N = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush;
  logic [1:0] count;

  int nvec;
  int nfail;

  pipe_reg_hs #(.N(N), .RESET_VAL(RV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       f;
    logic       ov;
    logic [7:0] od;
    logic [1:0] c;
    logic       ir;
  } vec_t;

  vec_t tbl[19];

  logic [7:0] q[$];
  logic [7:0] last;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [7:0] od,
                         input logic [1:0] c, input logic ir);
    chk({tag, ".out_valid"}, int'(out_valid), int'(ov));
    chk({tag, ".out_data"}, int'(out_data), int'(od));
    chk({tag, ".count"}, int'(count), int'(c));
    chk({tag, ".in_ready"}, int'(in_ready), int'(ir));
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d,
                            input logic r, input logic f);
    bit acc;
    bit pp;
    acc = v && (q.size() < 2);
    pp  = (q.size() > 0) && r;
    if (q.size() > 0) last = q[0];
    if (f) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
  endtask

  initial begin
    logic [7:0] hd;
    nvec = 0;
    nfail = 0;
    //          v  d      r  f   ov od    c  ir
    tbl[0]  = '{1, 8'h01, 1, 0,  1, 8'h01, 1, 1};
    tbl[1]  = '{1, 8'h02, 1, 0,  1, 8'h02, 1, 1};
    tbl[2]  = '{1, 8'h03, 1, 0,  1, 8'h03, 1, 1};
    tbl[3]  = '{1, 8'h04, 1, 0,  1, 8'h04, 1, 1};
    tbl[4]  = '{0, 8'h00, 1, 0,  0, 8'h04, 0, 1};
    tbl[5]  = '{1, 8'h0A, 1, 0,  1, 8'h0A, 1, 1};
    tbl[6]  = '{1, 8'h0B, 0, 0,  1, 8'h0A, 2, 0};
    tbl[7]  = '{1, 8'h0C, 0, 0,  1, 8'h0A, 2, 0};
    tbl[8]  = '{1, 8'h0C, 1, 0,  1, 8'h0B, 1, 1};
    tbl[9]  = '{1, 8'h0C, 1, 0,  1, 8'h0C, 1, 1};
    tbl[10] = '{0, 8'h00, 1, 0,  0, 8'h0C, 0, 1};
    tbl[11] = '{1, 8'h05, 0, 0,  1, 8'h05, 1, 1};
    tbl[12] = '{1, 8'h06, 1, 0,  1, 8'h06, 1, 1};
    tbl[13] = '{1, 8'h07, 0, 0,  1, 8'h06, 2, 0};
    tbl[14] = '{1, 8'h77, 0, 1,  0, 8'h06, 0, 1};
    tbl[15] = '{0, 8'h00, 1, 0,  0, 8'h06, 0, 1};
    tbl[16] = '{1, 8'h08, 1, 1,  0, 8'h06, 0, 1};
    tbl[17] = '{1, 8'h09, 0, 0,  1, 8'h09, 1, 1};
    tbl[18] = '{0, 8'h00, 1, 1,  0, 8'h09, 0, 1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, RV, 2'd0, 1'b1);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      out_ready = tbl[i].r;
      flush     = tbl[i].f;
      @(posedge clk);
      #1;
      chk_all($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].od, tbl[i].c, tbl[i].ir);
    end

    // Fill to FULL, then reset asynchronously between edges.
    in_valid  = 1'b1;
    in_data   = 8'h11;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    in_data = 8'h22;
    @(posedge clk);
    #1;
    chk("midrst.pre_count", int'(count), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("midrst", 1'b0, RV, 2'd0, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_vs_flush", 1'b0, RV, 2'd0, 1'b1);
    reset_n   = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("postrst%0d", i), 1'b0, RV, 2'd0, 1'b1);
    end

    q.delete();
    last = RV;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      model_edge(in_valid, in_data, out_ready, flush);
      @(posedge clk);
      #1;
      hd = (q.size() > 0) ? q[0] : last;
      chk_all("rand", q.size() > 0, hd, 2'(q.size()), q.size() < 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
